// File: rtl/dict_pkg.sv
// Shared types and defaults for the dictionary compressor front-end:
// FSM states, token layout and code-allocation bounds.
package dict_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RESULT,
    INSERT,
    INS_CHK,
    EMIT
  } state_t;

  localparam int TOKEN_W = 9;
  localparam int TOK_IS_CODE = 8;
  localparam int TOK_VAL_HI = 7;
  localparam int TOK_VAL_LO = 0;

  localparam logic [7:0] CODE_BASE_DEF = 8'd1;
  localparam logic [7:0] CODE_MAX_DEF  = 8'd255;

  // Token field order matches {is_code, value} at TOK_IS_CODE / TOK_VAL_HI..LO.
  typedef struct packed {
    logic       is_code;
    logic [7:0] value;
  } token_t;

endpackage

// File: rtl/dict_encoder.sv
// Byte-stream front-end: looks each byte up in the hash dictionary, emits a
// code on a hit or a literal on a miss, and allocates codes for new bytes.
module dict_encoder
  import dict_pkg::*;
#(
  parameter logic [7:0] CODE_BASE = CODE_BASE_DEF,
  parameter logic [7:0] CODE_MAX  = CODE_MAX_DEF,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_code,
  output logic [7:0]       out_value,
  output logic [7:0]       dict_key,
  output logic [7:0]       dict_data,
  output logic             dict_we,
  input  logic [7:0]       dict_rdata,
  input  logic             dict_hit,
  output logic             dict_full,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] lit_cnt
);

  state_t     state;
  logic [7:0] byte_q;
  logic [7:0] next_code;
  token_t     tok;

  assign in_ready    = (state == IDLE) && !reset;
  assign out_is_code = tok.is_code;
  assign out_value   = tok.value;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      byte_q    <= '0;
      next_code <= CODE_BASE;
      dict_full <= 1'b0;
      tok       <= '0;
      out_valid <= 1'b0;
      dict_key  <= '0;
      dict_data <= '0;
      dict_we   <= 1'b0;
      hit_cnt   <= '0;
      lit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            byte_q   <= in_byte;
            dict_key <= in_byte;
            state    <= LOOKUP;
          end
        end
        LOOKUP: state <= RESULT;
        RESULT: begin
          if (dict_hit) begin
            tok       <= {1'b1, dict_rdata};
            out_valid <= 1'b1;
            state     <= EMIT;
          end else if (byte_q != 8'd0 && !dict_full) begin
            // 0x00 is the dictionary's empty marker and can never be stored.
            dict_we   <= 1'b1;
            dict_data <= next_code;
            state     <= INSERT;
          end else begin
            tok       <= {1'b0, byte_q};
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        INSERT: begin
          dict_we   <= 1'b0;
          dict_data <= '0;
          state     <= INS_CHK;
        end
        INS_CHK: begin
          // A failed write (bucket chain full) leaves the code free for the next byte.
          if (dict_hit) begin
            if (next_code == CODE_MAX) dict_full <= 1'b1;
            else                       next_code <= next_code + 8'd1;
          end
          tok       <= {1'b0, byte_q};
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (tok.is_code) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
              if (lit_cnt != '1) lit_cnt <= lit_cnt + 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
